// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM state encoding and default frame header
// for the byte-serial program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    CHECK = 3'd4,
    RUN   = 3'd5
  } loader_state_t;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream -> big-endian 16-bit imem writes; holds
// cpu_en low until a checksum-verified image is in place.
// Ports: clk, rst (async high); rx_valid/rx_data/rx_ready byte link;
// mem_we/mem_addr/mem_wdata imem write port; cpu_en, done, err status.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  HDR    = LOADER_HDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_en,
  output logic              done,
  output logic              err
);

  localparam int unsigned CAP = 32'd1 << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [15:0]       word_q, word_d;
  logic              we_q, we_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;

  // The write strobe cycle is the only stall; it lets the address
  // advance before the next HI byte.
  assign rx_ready = ~rst & ~we_q;
  assign xfer     = rx_valid & rx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    word_d  = word_q;
    we_d    = 1'b0;
    run_d   = run_q;
    done_d  = done_q;
    err_d   = err_q;

    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (xfer) begin
      unique case (state_q)
        IDLE, RUN: begin
          if (rx_data == HDR) begin
            state_d = COUNT;
            err_d   = 1'b0;
            done_d  = 1'b0;
            run_d   = 1'b0;
            chk_d   = 8'h00;
            addr_d  = '0;
          end
        end
        COUNT: begin
          if ({24'd0, rx_data} > CAP) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (rx_data == 8'h00) begin
            state_d = CHECK;
          end else begin
            cnt_d   = rx_data;
            state_d = HI;
          end
        end
        HI: begin
          word_d[15:8] = rx_data;
          chk_d        = chk_q ^ rx_data;
          state_d      = LO;
        end
        LO: begin
          word_d[7:0] = rx_data;
          chk_d       = chk_q ^ rx_data;
          we_d        = 1'b1;
          cnt_d       = cnt_q - 8'd1;
          state_d     = (cnt_q == 8'd1) ? CHECK : HI;
        end
        CHECK: begin
          if (rx_data == chk_q) begin
            done_d  = 1'b1;
            run_d   = 1'b1;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= 8'h00;
      chk_q   <= 8'h00;
      word_q  <= 16'h0000;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      word_q  <= word_d;
      we_q    <= we_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign cpu_en    = run_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
